// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
//  Single-entry dispatcher that takes one valid/ready item stream and steers
//  each item to one of four consumers via the demux select {s1,s0}.
//  Destinations rotate round-robin over enabled channels, MAX_BURST items
//  per channel before moving on.
//  Optional feature: define DEMUX_RETARGET_EN to move an item that has been
//  stalled for TIMEOUT cycles to the next enabled channel.
//
//  Handshake: a transfer happens on a rising clk edge where valid and ready
//  are both high; valid never waits on ready, and a presented item (out_data,
//  {s1,s0}) holds steady until its consumer takes it.
module demux_rr_dispatcher #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ch_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              s1,
    output logic              s0,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        out_ready,
    output logic              retarget
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [0:0]        state;
    logic [1:0]        sel;
    logic [1:0]        ptr;
    logic [1:0]        dest;
    logic [BW-1:0]     burst_cnt;
    logic [BW-1:0]     eff_cnt;
    logic              last_in_burst;
    logic [DATA_W-1:0] hold;
    logic              fire;
    logic              accept;
    logic              timeout_hit;

    assign fire     = (state == FULL) & out_ready[sel];
    assign in_ready = (|ch_en) & ((state == EMPTY) | fire);
    assign accept   = in_valid & in_ready;

    assign s1        = sel[1];
    assign s0        = sel[0];
    assign out_data  = hold;
    assign out_valid = (state == FULL) ? (4'd1 << sel) : 4'd0;

    // First enabled channel at or after ptr, searching cyclically.
    always_comb begin
        logic [1:0] idx;
        dest = ptr;
        idx  = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (ch_en[idx]) dest = idx;
        end
    end

    // If ptr's channel was skipped, the item opens a fresh burst on dest,
    // so it counts as the first item of that burst rather than continuing
    // a count that belonged to another channel.
    always_comb begin
        eff_cnt       = (dest == ptr) ? burst_cnt : '0;
        last_in_burst = (32'(eff_cnt) == MAX_BURST - 1);
    end

`ifdef DEMUX_RETARGET_EN
    localparam int WW = $clog2(TIMEOUT);

    logic [WW-1:0] wait_cnt;
    logic [1:0]    nxt;
    logic          other_en;
    logic          retarget_q;

    // Next enabled channel strictly after the current destination.
    always_comb begin
        logic [1:0] idx;
        nxt      = sel;
        other_en = 1'b0;
        idx      = sel;
        for (int i = 3; i >= 1; i--) begin
            idx = sel + 2'(i);
            if (ch_en[idx]) begin
                nxt      = idx;
                other_en = 1'b1;
            end
        end
    end

    assign timeout_hit = (state == FULL) & ~fire & (32'(wait_cnt) == TIMEOUT - 1) & other_en;
    assign retarget    = retarget_q;

    // Stall counter; saturates so a retarget still happens once another channel is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            retarget_q <= 1'b0;
        end else begin
            retarget_q <= timeout_hit;
            if ((state != FULL) || fire || timeout_hit) begin
                wait_cnt <= '0;
            end else if (32'(wait_cnt) != TIMEOUT - 1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign retarget    = 1'b0;
`endif

    // Hold register, select, round-robin pointer and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            hold      <= '0;
            sel       <= 2'd0;
            ptr       <= 2'd0;
            burst_cnt <= '0;
        end else begin
            if (accept) begin
                state <= FULL;
            end else if (fire) begin
                state <= EMPTY;
            end

            if (accept) begin
                hold <= in_data;
                sel  <= dest;
                if (last_in_burst) begin
                    ptr       <= dest + 2'd1;
                    burst_cnt <= '0;
                end else begin
                    ptr       <= dest;
                    burst_cnt <= eff_cnt + 1'b1;
                end
            end
`ifdef DEMUX_RETARGET_EN
            else if (timeout_hit) begin
                sel       <= nxt;
                ptr       <= nxt + 2'd1;
                burst_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Testbench for demux_rr_dispatcher: per-cycle vector table plus hand-written
// reset and long-stall sequences, with a delivery scoreboard on the outputs.
module tb_demux_rr_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_en;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       s1, s0;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic       retarget;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp_ch_q[$];

    typedef struct {
        logic [3:0] ch_en;
        logic       iv;
        logic [7:0] din;
        logic [3:0] ordy;
        logic       e_rdy;
        logic [3:0] e_ov;
        logic [1:0] e_sel;
        logic [7:0] e_data;
    } vec_t;

    vec_t vq[$];

    demux_rr_dispatcher #(.DATA_W(8), .MAX_BURST(2), .TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .s1       (s1),
        .s0       (s0),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .retarget (retarget)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic iv, input logic [7:0] d, input logic [3:0] r,
                       input logic er, input logic [3:0] eov, input logic [1:0] es, input logic [7:0] ed);
        vec_t v;
        v.ch_en = c; v.iv = iv; v.din = d; v.ordy = r;
        v.e_rdy = er; v.e_ov = eov; v.e_sel = es; v.e_data = ed;
        vq.push_back(v);
    endtask

    task automatic expect_item(input logic [7:0] d, input logic [1:0] c);
        exp_q.push_back(d);
        exp_ch_q.push_back(c);
    endtask

    // scoreboard: every delivered item must be the next expected one on the expected channel
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < 4; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_delivery", {24'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("deliver_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                        chk("deliver_ch", c, {30'd0, exp_ch_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        int n_stall;
        int n_pulse;
        bit seen2;

        rst = 1'b1; ch_en = 4'hF; in_valid = 1'b0; in_data = 8'h00; out_ready = 4'hF;

        // back-to-back stream, all channels enabled
        add(4'hF,1,8'h10,4'hF, 1,4'h0,2'd0,8'h00);
        add(4'hF,1,8'h11,4'hF, 1,4'h1,2'd0,8'h10);
        add(4'hF,1,8'h12,4'hF, 1,4'h1,2'd0,8'h11);
        add(4'hF,1,8'h13,4'hF, 1,4'h2,2'd1,8'h12);
        add(4'hF,1,8'h14,4'hF, 1,4'h2,2'd1,8'h13);
        add(4'hF,1,8'h15,4'hF, 1,4'h4,2'd2,8'h14);
        add(4'hF,1,8'h16,4'hF, 1,4'h4,2'd2,8'h15);
        add(4'hF,1,8'h17,4'hF, 1,4'h8,2'd3,8'h16);
        add(4'hF,0,8'h00,4'hF, 1,4'h8,2'd3,8'h17);
        add(4'hF,0,8'h00,4'hF, 1,4'h0,2'd3,8'h17);
        // channels 1 and 3 only
        add(4'hA,1,8'h20,4'hF, 1,4'h0,2'd3,8'h17);
        add(4'hA,1,8'h21,4'hF, 1,4'h2,2'd1,8'h20);
        add(4'hA,1,8'h22,4'hF, 1,4'h2,2'd1,8'h21);
        add(4'hA,1,8'h23,4'hF, 1,4'h8,2'd3,8'h22);
        add(4'hA,1,8'h24,4'hF, 1,4'h8,2'd3,8'h23);
        add(4'hA,1,8'h25,4'hF, 1,4'h2,2'd1,8'h24);
        add(4'hA,0,8'h00,4'hF, 1,4'h2,2'd1,8'h25);
        add(4'hA,0,8'h00,4'hF, 1,4'h0,2'd1,8'h25);
        // consumer 0 stalls for 5 cycles with an item held
        add(4'h1,1,8'h30,4'hE, 1,4'h0,2'd1,8'h25);
        for (int i = 0; i < 5; i++) add(4'h1,1,8'h31,4'hE, 0,4'h1,2'd0,8'h30);
        add(4'h1,1,8'h31,4'hF, 1,4'h1,2'd0,8'h30);
        add(4'h1,0,8'h00,4'hF, 1,4'h1,2'd0,8'h31);
        add(4'h1,0,8'h00,4'hF, 1,4'h0,2'd0,8'h31);
        // no channel enabled, then only channel 2
        add(4'h0,1,8'h40,4'hF, 0,4'h0,2'd0,8'h31);
        add(4'h0,1,8'h40,4'hF, 0,4'h0,2'd0,8'h31);
        add(4'h4,1,8'h40,4'hF, 1,4'h0,2'd0,8'h31);
        add(4'h4,0,8'h00,4'hF, 1,4'h4,2'd2,8'h40);
        add(4'h4,0,8'h00,4'hF, 1,4'h0,2'd2,8'h40);

        expect_item(8'h10,0); expect_item(8'h11,0); expect_item(8'h12,1); expect_item(8'h13,1);
        expect_item(8'h14,2); expect_item(8'h15,2); expect_item(8'h16,3); expect_item(8'h17,3);
        expect_item(8'h20,1); expect_item(8'h21,1); expect_item(8'h22,3); expect_item(8'h23,3);
        expect_item(8'h24,1); expect_item(8'h25,1);
        expect_item(8'h30,0); expect_item(8'h31,0); expect_item(8'h40,2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {28'd0, out_valid}, 32'd0);
        chk("reset_sel", {30'd0, s1, s0}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_retarget", {31'd0, retarget}, 32'd0);
        rst = 1'b0;

        // table-driven vectors, one per cycle
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            ch_en = vq[i].ch_en; in_valid = vq[i].iv; in_data = vq[i].din; out_ready = vq[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vq[i].e_rdy});
            chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vq[i].e_ov});
            chk($sformatf("v%0d_sel", i), {30'd0, s1, s0}, {30'd0, vq[i].e_sel});
            chk($sformatf("v%0d_out_data", i), {24'd0, out_data}, {24'd0, vq[i].e_data});
            chk($sformatf("v%0d_retarget", i), {31'd0, retarget}, 32'd0);
        end

        // asynchronous reset while an item is held on channel 2
        @(posedge clk); #1;
        ch_en = 4'hF; in_valid = 1'b1; in_data = 8'h50; out_ready = 4'h0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk("held_before_reset", {28'd0, out_valid}, 32'h4);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("async_rst_sel", {30'd0, s1, s0}, 32'd0);
        chk("async_rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 4'hF; in_valid = 1'b1; in_data = 8'h51;
        expect_item(8'h51, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk("post_reset_sel", {30'd0, s1, s0}, 32'd0);
        chk("post_reset_out_valid", {28'd0, out_valid}, 32'h1);
        chk("post_reset_out_data", {24'd0, out_data}, 32'h51);

        // long stall on channel 1 with other channels enabled
        @(posedge clk); #1;
        ch_en = 4'h2; in_valid = 1'b1; in_data = 8'h60; out_ready = 4'hD;
        @(posedge clk); #1;
        in_valid = 1'b0; ch_en = 4'hF;
`ifdef DEMUX_RETARGET_EN
        expect_item(8'h60, 2);
`endif
        n_stall = 0; n_pulse = 0; seen2 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if ({s1, s0} == 2'd1 && out_valid == 4'h2 && out_data == 8'h60) n_stall++;
            if (retarget) n_pulse++;
            if ({s1, s0} == 2'd2 && out_valid == 4'h4 && out_data == 8'h60) seen2 = 1'b1;
            @(posedge clk); #1;
        end
`ifdef DEMUX_RETARGET_EN
        chk("retarget_stall_cycles", n_stall, 32'd4);
        chk("retarget_pulses", n_pulse, 32'd1);
        chk("retarget_on_ch2", {31'd0, seen2}, 32'd1);
`else
        chk("hold_stall_cycles", n_stall, 32'd12);
        chk("hold_no_retarget", n_pulse, 32'd0);
        chk("hold_not_moved", {31'd0, seen2}, 32'd0);
`endif

        @(posedge clk); #1;
        chk("all_items_delivered", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
